// File: rtl/axi4l_pkg.sv
// Shared constants and width helpers for the AXI4-Lite write pipeline.
package axi4l_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

   // Number of address bits that select a byte inside one data word.
   function automatic int offs_width(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi4l_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty use an extra pointer bit.
module axi4l_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
)(
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign dout  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk_sys) begin
      if (push && !full)
         mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/s_axi4l_wr_pipe.sv
// AXI4-Lite write slave: buffered AW/W channels, in-order pairing, register decode.
module s_axi4l_wr_pipe
   import axi4l_pkg::*;
#(
   parameter  int ADDR_WIDTH = 32,
   parameter  int DATA_WIDTH = 32,
   parameter  int FIFO_DEPTH = 2,
   parameter  int REG_COUNT  = 16,
   localparam int STRB_WIDTH = strb_width(DATA_WIDTH),
   localparam int IDX_WIDTH  = $clog2(REG_COUNT)
)(
   input  logic                  i_axi_clock,
   input  logic                  i_axi_reset,
   input  logic [ADDR_WIDTH-1:0] i_axi_awaddr,
   input  logic [2:0]            i_axi_awprot,
   input  logic                  i_axi_awaddr_valid,
   output logic                  o_axi_awaddr_ready,
   input  logic [DATA_WIDTH-1:0] i_axi_wdata,
   input  logic [STRB_WIDTH-1:0] i_axi_wstrb,
   input  logic                  i_axi_wdata_valid,
   output logic                  o_axi_wdata_ready,
   output logic [1:0]            o_axi_bresp,
   output logic                  o_axi_bvalid,
   input  logic                  i_axi_bready,
   output logic [IDX_WIDTH-1:0]  o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [STRB_WIDTH-1:0] o_wstrb,
   output logic                  o_wvalid
);

   localparam int                    OFFS_WIDTH = offs_width(DATA_WIDTH);
   localparam int                    W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(REG_COUNT);

   logic                  aw_full;
   logic                  aw_empty;
   logic                  aw_push;
   logic [ADDR_WIDTH-1:0] aw_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic [W_WIDTH-1:0]    w_head;
   logic [DATA_WIDTH-1:0] head_data;
   logic [STRB_WIDTH-1:0] head_strb;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  b_free;
   logic                  issue;
   logic                  in_range;
   logic                  do_write;
   logic [2:0]            unused_awprot;

   assign unused_awprot = i_axi_awprot;

   assign o_axi_awaddr_ready = !aw_full && !i_axi_reset;
   assign o_axi_wdata_ready  = !w_full && !i_axi_reset;
   assign aw_push            = i_axi_awaddr_valid && o_axi_awaddr_ready;
   assign w_push             = i_axi_wdata_valid && o_axi_wdata_ready;

   axi4l_sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_aw_fifo (
      .clk_sys (i_axi_clock),
      .rst     (i_axi_reset),
      .push    (aw_push),
      .pop     (issue),
      .full    (aw_full),
      .empty   (aw_empty),
      .din     (i_axi_awaddr),
      .dout    (aw_head)
   );

   axi4l_sync_fifo #(
      .WIDTH (W_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_w_fifo (
      .clk_sys (i_axi_clock),
      .rst     (i_axi_reset),
      .push    (w_push),
      .pop     (issue),
      .full    (w_full),
      .empty   (w_empty),
      .din     ({i_axi_wstrb, i_axi_wdata}),
      .dout    (w_head)
   );

   // A new response may be launched in the same cycle the previous one is accepted.
   assign b_free = !o_axi_bvalid || i_axi_bready;
   assign issue  = !aw_empty && !w_empty && b_free && !i_axi_reset;

   assign {head_strb, head_data} = w_head;
   assign word_addr = aw_head >> OFFS_WIDTH;
   assign in_range  = (word_addr < REG_LIMIT);
   assign do_write  = in_range && (head_strb != '0);

   always_ff @(posedge i_axi_clock) begin
      if (i_axi_reset) begin
         o_axi_bvalid <= 1'b0;
         o_axi_bresp  <= RESP_OKAY;
         o_wvalid     <= 1'b0;
         o_waddr      <= '0;
         o_wdata      <= '0;
         o_wstrb      <= '0;
      end else begin
         o_wvalid <= issue && do_write;
         if (issue) begin
            o_axi_bvalid <= 1'b1;
            o_axi_bresp  <= in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (i_axi_bready) begin
            o_axi_bvalid <= 1'b0;
         end
         if (issue && do_write) begin
            o_waddr <= word_addr[IDX_WIDTH-1:0];
            o_wdata <= head_data;
            o_wstrb <= head_strb;
         end
      end
   end

endmodule

// File: tb/tb_s_axi4l_wr_pipe.sv
// Testbench for s_axi4l_wr_pipe: queue-based reference model plus directed scenarios.
module tb_s_axi4l_wr_pipe;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  waddr_o;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb_o;
   logic        wvalid_o;

   logic [31:0] a64_addr;
   logic        a64_valid;
   logic        a64_ready;
   logic [63:0] w64_data;
   logic [7:0]  w64_strb;
   logic        w64_valid;
   logic        w64_ready;
   logic [1:0]  b64_resp;
   logic        b64_valid;
   logic        b64_ready;
   logic [3:0]  o64_waddr;
   logic [63:0] o64_wdata;
   logic [7:0]  o64_wstrb;
   logic        o64_wvalid;

   s_axi4l_wr_pipe dut (
      .i_axi_clock        (clk),
      .i_axi_reset        (rst),
      .i_axi_awaddr       (awaddr),
      .i_axi_awprot       (awprot),
      .i_axi_awaddr_valid (awvalid),
      .o_axi_awaddr_ready (awready),
      .i_axi_wdata        (wdata),
      .i_axi_wstrb        (wstrb),
      .i_axi_wdata_valid  (wvalid),
      .o_axi_wdata_ready  (wready),
      .o_axi_bresp        (bresp),
      .o_axi_bvalid       (bvalid),
      .i_axi_bready       (bready),
      .o_waddr            (waddr_o),
      .o_wdata            (wdata_o),
      .o_wstrb            (wstrb_o),
      .o_wvalid           (wvalid_o)
   );

   s_axi4l_wr_pipe #(.DATA_WIDTH(64)) dut64 (
      .i_axi_clock        (clk),
      .i_axi_reset        (rst),
      .i_axi_awaddr       (a64_addr),
      .i_axi_awprot       (3'b000),
      .i_axi_awaddr_valid (a64_valid),
      .o_axi_awaddr_ready (a64_ready),
      .i_axi_wdata        (w64_data),
      .i_axi_wstrb        (w64_strb),
      .i_axi_wdata_valid  (w64_valid),
      .o_axi_wdata_ready  (w64_ready),
      .o_axi_bresp        (b64_resp),
      .o_axi_bvalid       (b64_valid),
      .i_axi_bready       (b64_ready),
      .o_waddr            (o64_waddr),
      .o_wdata            (o64_wdata),
      .o_wstrb            (o64_wstrb),
      .o_wvalid           (o64_wvalid)
   );

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic void timeout_fail(input string name);
      n_chk++;
      $display("FAIL %s: handshake timed out", name);
   endfunction

   // Reference model: two bounded queues and one outstanding response slot.
   logic [31:0] m_aw [$];
   logic [35:0] m_w  [$];
   logic        m_bvalid, m_wvalid;
   logic [1:0]  m_bresp;
   logic [3:0]  m_waddr, m_wstrb;
   logic [31:0] m_wdata;
   logic [31:0] m_a, m_idx;
   logic [35:0] m_wd;
   bit          m_aw_acc, m_w_acc, m_iss;
   bit          model_on = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_aw.delete();
         m_w.delete();
         m_bvalid = 0; m_bresp = 0; m_wvalid = 0;
         m_waddr = 0; m_wdata = 0; m_wstrb = 0;
         model_on = 1;
      end else begin
         m_aw_acc = awvalid && (m_aw.size() < DEPTH);
         m_w_acc  = wvalid && (m_w.size() < DEPTH);
         m_iss    = (m_aw.size() > 0) && (m_w.size() > 0) && (!m_bvalid || bready);
         m_wvalid = 0;
         if (m_iss) begin
            m_a   = m_aw.pop_front();
            m_wd  = m_w.pop_front();
            m_idx = m_a / 4;
            m_bvalid = 1;
            m_bresp  = (m_idx < 16) ? 2'b00 : 2'b10;
            if (m_idx < 16 && m_wd[35:32] != 4'h0) begin
               m_wvalid = 1;
               m_waddr  = m_idx[3:0];
               m_wdata  = m_wd[31:0];
               m_wstrb  = m_wd[35:32];
            end
         end else if (bready) begin
            m_bvalid = 0;
         end
         if (m_aw_acc) m_aw.push_back(awaddr);
         if (m_w_acc)  m_w.push_back({wstrb, wdata});
      end
   end

   logic [35:0] wlog [$];
   logic [1:0]  blog [$];

   always begin
      @(negedge clk);
      #1;
      if (model_on) begin
         chk("awready", awready, !rst && (m_aw.size() < DEPTH));
         chk("wready",  wready,  !rst && (m_w.size() < DEPTH));
         chk("bvalid",  bvalid,  m_bvalid);
         chk("bresp",   bresp,   m_bresp);
         chk("wvalid",  wvalid_o, m_wvalid);
         if (m_wvalid) begin
            chk("waddr", waddr_o, m_waddr);
            chk("wdata", wdata_o, m_wdata);
            chk("wstrb", wstrb_o, m_wstrb);
         end
         if (wvalid_o) wlog.push_back({waddr_o, wdata_o});
         if (bvalid && bready) blog.push_back(bresp);
      end
   end

   task automatic aw_send(input logic [31:0] a);
      int t = 0;
      awaddr = a; awvalid = 1;
      while (!awready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) timeout_fail("aw_send");
      @(negedge clk);
      awvalid = 0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s);
      int t = 0;
      wdata = d; wstrb = s; wvalid = 1;
      while (!wready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) timeout_fail("w_send");
      @(negedge clk);
      wvalid = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return $urandom;
      return ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
   endfunction

   function automatic logic [3:0] rand_strb();
      if ($urandom_range(0, 4) == 0) return 4'h0;
      return 4'($urandom);
   endfunction

   logic [31:0] bp_addr [4] = '{32'h4, 32'h44, 32'h8, 32'hC};
   bit  aw_done, w_done, aw_go, w_go;
   int  t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
      a64_addr = 0; a64_valid = 0; w64_data = 0; w64_strb = 0; w64_valid = 0; b64_ready = 1;
      repeat (3) @(negedge clk);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_wvalid", wvalid_o, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_wstrb", wstrb_o, 0);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      rst = 0;
      @(negedge clk);
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);

      // single write, two-cycle latency
      fork
         aw_send(32'h8);
         w_send(32'hDEAD_BEEF, 4'hF);
      join
      @(negedge clk);
      chk("single_wvalid", wvalid_o, 1);
      chk("single_waddr", waddr_o, 2);
      chk("single_wdata", wdata_o, 32'hDEAD_BEEF);
      chk("single_wstrb", wstrb_o, 4'hF);
      chk("single_bvalid", bvalid, 1);
      chk("single_bresp", bresp, 2'b00);
      @(negedge clk);
      chk("single_pulse_end", wvalid_o, 0);

      // out of range
      fork
         aw_send(32'h40);
         w_send(32'h1234_5678, 4'hF);
      join
      @(negedge clk);
      chk("oor_bvalid", bvalid, 1);
      chk("oor_bresp", bresp, 2'b10);
      chk("oor_wvalid", wvalid_o, 0);
      repeat (3) @(negedge clk);

      // channel skew
      wlog.delete();
      fork
         begin
            aw_send(32'h0); aw_send(32'h4); aw_send(32'hC);
         end
         begin
            repeat (6) @(negedge clk);
            chk("skew_awready_full", awready, 0);
            chk("skew_wready", wready, 1);
            w_send(32'h11, 4'hF); w_send(32'h22, 4'hF); w_send(32'h33, 4'hF);
         end
      join
      repeat (5) @(negedge clk);
      chk("skew_count", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("skew_w0", wlog[0], {4'd0, 32'h11});
         chk("skew_w1", wlog[1], {4'd1, 32'h22});
         chk("skew_w2", wlog[2], {4'd3, 32'h33});
      end

      // B backpressure
      blog.delete();
      bready = 0; aw_done = 0; w_done = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) aw_send(bp_addr[i]);
            aw_done = 1;
         end
         begin
            for (int i = 0; i < 4; i++) w_send(32'hA0 + i, 4'hF);
            w_done = 1;
         end
      join_none
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid_hold", bvalid, 1);
         chk("bp_bresp_hold", bresp, 2'b00);
         @(negedge clk);
      end
      chk("bp_wready_low", wready, 0);
      bready = 1;
      t = 0;
      while (!(aw_done && w_done) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout_fail("bp_drain");
      repeat (5) @(negedge clk);
      chk("bp_count", blog.size(), 4);
      if (blog.size() == 4) begin
         chk("bp_r0", blog[0], 2'b00);
         chk("bp_r1", blog[1], 2'b10);
         chk("bp_r2", blog[2], 2'b00);
         chk("bp_r3", blog[3], 2'b00);
      end

      // reset mid-stream
      bready = 0;
      fork
         begin aw_send(32'h0); aw_send(32'h4); aw_send(32'h8); end
         begin w_send(32'h51, 4'hF); w_send(32'h52, 4'hF); w_send(32'h53, 4'hF); end
      join
      chk("mid_bvalid_before", bvalid, 1);
      wlog.delete();
      rst = 1;
      @(negedge clk);
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_wvalid", wvalid_o, 0);
      chk("mid_rst_waddr", waddr_o, 0);
      chk("mid_rst_wdata", wdata_o, 0);
      chk("mid_rst_awready", awready, 0);
      rst = 0; bready = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_no_stale_b", bvalid, 0);
         chk("mid_no_stale_w", wvalid_o, 0);
      end
      chk("mid_wlog_empty", wlog.size(), 0);

      // 64-bit instance: partial and empty strobes
      chk("d64_awready", a64_ready, 1);
      a64_addr = 32'h10; a64_valid = 1; w64_data = 64'h0123_4567_89AB_CDEF; w64_strb = 8'h0F; w64_valid = 1;
      @(negedge clk);
      a64_valid = 0; w64_valid = 0;
      @(negedge clk);
      chk("d64_wvalid", o64_wvalid, 1);
      chk("d64_waddr", o64_waddr, 2);
      chk("d64_wstrb", o64_wstrb, 8'h0F);
      chk("d64_wdata", o64_wdata, 64'h0123_4567_89AB_CDEF);
      chk("d64_bresp", b64_resp, 2'b00);
      a64_addr = 32'h18; a64_valid = 1; w64_data = 64'hFFFF; w64_strb = 8'h00; w64_valid = 1;
      @(negedge clk);
      a64_valid = 0; w64_valid = 0;
      @(negedge clk);
      chk("d64_zero_wvalid", o64_wvalid, 0);
      chk("d64_zero_bvalid", b64_valid, 1);
      chk("d64_zero_bresp", b64_resp, 2'b00);

      // randomized traffic against the model
      aw_go = 0; w_go = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (!awvalid || aw_go) begin
            awvalid = ($urandom_range(0, 3) != 0);
            awaddr  = rand_addr();
            awprot  = 3'($urandom);
         end
         if (!wvalid || w_go) begin
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = $urandom;
            wstrb  = rand_strb();
         end
         bready = ($urandom_range(0, 3) != 0);
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0; bready = 1;
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/s_axi4l_wr_pipe.md
# s_axi4l_wr_pipe

Parametrised AXI4-Lite write-channel slave, the successor of `s_axi4l_wr_channel`. It buffers the AW and W channels independently in per-channel FIFOs, pairs them in order, and decodes the word address against a configurable register count. It drives a byte-strobed single-cycle write to the register file, or returns SLVERR without writing. It sits between the AXI4-Lite interconnect and the register file.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width, 32 or 64. STRB_WIDTH = DATA_WIDTH/8.
- FIFO_DEPTH, 2: entries per AW/W FIFO, power of two, ≥2.
- REG_COUNT, 16: number of decoded registers. IDX_WIDTH = $clog2(REG_COUNT).

- i_axi_clock  in  1  clock; all logic on rising edge.
- i_axi_reset  in  1  synchronous, active-high reset.
- i_axi_awaddr  in  ADDR_WIDTH  write address.
- i_axi_awprot  in  3  accepted, ignored.
- i_axi_awaddr_valid / o_axi_awaddr_ready  in/out  1  AW handshake.
- i_axi_wdata  in  DATA_WIDTH  write data.
- i_axi_wstrb  in  STRB_WIDTH  byte strobes.
- i_axi_wdata_valid / o_axi_wdata_ready  in/out  1  W handshake.
- o_axi_bresp  out  2  write response.
- o_axi_bvalid / i_axi_bready  out/in  1  B handshake.
- o_waddr  out  IDX_WIDTH  register word index.
- o_wdata  out  DATA_WIDTH  register write data.
- o_wstrb  out  STRB_WIDTH  register byte enables.
- o_wvalid  out  1  single-cycle register write strobe, no backpressure.

## Operation
- AW handshake (valid & ready) pushes awaddr into the AW FIFO. W handshake pushes {wstrb, wdata} into the W FIFO. The two channels are fully independent, so either may lead by up to FIFO_DEPTH transactions.
- Ready flags: o_axi_awaddr_ready = !aw_full, o_axi_wdata_ready = !w_full. Both are forced 0 while i_axi_reset = 1. There is no push-while-full bypass.
- Issue condition: AW FIFO non-empty, W FIFO non-empty, and the B slot is free, where free means (!o_axi_bvalid || i_axi_bready). On issue, both FIFO heads are popped in the same cycle.
- Decode:
  - idx = awaddr[ADDR_WIDTH-1 : log2(STRB_WIDTH)]. Low byte-offset bits are ignored.
  - idx < REG_COUNT: bresp = OKAY (2'b00). If wstrb != 0, a register write is issued; if wstrb == 0, no register write, bresp = OKAY.
  - idx ≥ REG_COUNT: bresp = SLVERR (2'b10), no register write.
- Register write: on the cycle after issue, o_wvalid = 1 for exactly one cycle, with o_waddr = idx[IDX_WIDTH-1:0] and o_wdata/o_wstrb taken from the W FIFO head.
- Response:
  - o_axi_bvalid is set on the cycle after issue together with o_axi_bresp.
  - bvalid and bresp hold stable until i_axi_bready is sampled high.
  - Responses are returned in AW order.

## Timing
- Reset values: o_axi_bvalid 0, o_axi_bresp 2'b00, o_wvalid 0, o_waddr 0, o_wdata 0, o_wstrb 0. Both FIFOs are empty and both ready flags are 0.
- Ready flags rise in the first cycle after reset deasserts.
- Latency: AW and W handshake together in cycle N, with the FIFOs empty and the B slot free.
  - Issue in cycle N+1.
  - o_wvalid and o_axi_bvalid high in cycle N+2.
- Throughput: one write per cycle sustained while i_axi_bready = 1 and both channels stream.
- Backpressure:
  - While bready = 0 and bvalid = 1, issue stalls.
  - The FIFOs keep accepting until full, then the corresponding ready drops.
- Simultaneous push and pop on a non-full FIFO is legal; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer bit.
- Reset mid-operation: FIFOs are flushed, any pending B response is dropped, and a same-cycle o_wvalid is suppressed.

## Structure
- Package axi4l_pkg holds:
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - localparam helpers for STRB_WIDTH and the byte-offset width.
- Sub-module axi4l_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, din, dout with first-word fall-through). It is instantiated twice:
  - AW FIFO, WIDTH = ADDR_WIDTH;
  - W FIFO, WIDTH = DATA_WIDTH + STRB_WIDTH.
- The top level holds the issue logic, decode, and the B/register output registers.

## Test plan
- Single write (defaults): AW 0x0000_0008 and W 0xDEAD_BEEF with wstrb 4'hF in the same cycle, bready = 1 → two cycles later o_wvalid pulse with o_waddr = 2, o_wdata = 0xDEAD_BEEF, o_wstrb = 4'hF; bvalid with bresp = 2'b00.
- Out of range: AW 0x0000_0040 (idx 16) → no o_wvalid; bresp = 2'b10.
- Channel skew: three AW (0x0, 0x4, 0xC) with W held off, then W 0x11, 0x22, 0x33 → the third AW stalls with awready = 0 while the FIFO is full (depth 2). Writes arrive in order: idx 0/0x11, idx 1/0x22, idx 3/0x33.
- B backpressure: bready = 0 for 5 cycles during a stream of 4 writes → bvalid/bresp stay stable, wready drops after two W are buffered, and all 4 responses complete in order once bready = 1.
- Partial strobe at DATA_WIDTH = 64: AW 0x10, wstrb 8'h0F → o_waddr = 2, o_wstrb = 8'h0F. With wstrb 8'h00 → no o_wvalid, bresp = OKAY.
- Reset mid-stream: assert i_axi_reset for one cycle with 2 pending entries and bvalid = 1 → all outputs return to reset values, and no stale write or response appears afterward.
